// File: rtl/tlp_tx_arbiter_if.sv
// TLP transmit arbiter bus: per-requester beat inputs, shared PCIe tx output,
// debug status. pktCount_out exists only when TX_ARB_STATS_EN is defined.
// master = arbiter side, slave = requesters plus PCIe core side.
interface tlp_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0][63:0] reqData_in;
  logic [NUM_REQ-1:0]       reqSOP_in;
  logic [NUM_REQ-1:0]       reqEOP_in;
  logic [NUM_REQ-1:0]       reqValid_in;
  logic [NUM_REQ-1:0]       reqReady_out;
  logic [63:0]              txData_out;
  logic                     txSOP_out;
  logic                     txEOP_out;
  logic                     txValid_out;
  logic                     txReady_in;
  logic [IDX_W-1:0]         owner_out;
  logic                     busy_out;
`ifdef TX_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] pktCount_out;

  modport master (
    input  reqData_in, reqSOP_in, reqEOP_in, reqValid_in, txReady_in,
    output reqReady_out, txData_out, txSOP_out, txEOP_out, txValid_out,
    output owner_out, busy_out, pktCount_out
  );
  modport slave (
    output reqData_in, reqSOP_in, reqEOP_in, reqValid_in, txReady_in,
    input  reqReady_out, txData_out, txSOP_out, txEOP_out, txValid_out,
    input  owner_out, busy_out, pktCount_out
  );
`else
  modport master (
    input  reqData_in, reqSOP_in, reqEOP_in, reqValid_in, txReady_in,
    output reqReady_out, txData_out, txSOP_out, txEOP_out, txValid_out,
    output owner_out, busy_out
  );
  modport slave (
    output reqData_in, reqSOP_in, reqEOP_in, reqValid_in, txReady_in,
    input  reqReady_out, txData_out, txSOP_out, txEOP_out, txValid_out,
    input  owner_out, busy_out
  );
`endif
endinterface

// File: rtl/tlp_tx_arbiter.sv
// Packet-granular round-robin arbiter of NUM_REQ TLP sources onto one PCIe tx pipe.
// Latency: accepted beat appears on tx outputs 1 cycle later (empty buffer); 2-entry skid buffer.
// Backpressure: owner ready = buffer not full (registered only); optional TX_ARB_STATS_EN adds per-requester packet counters.
module tlp_tx_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic           pcieClk_in,
  input  logic           pcieNReset_in,
  tlp_tx_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [65:0]      buf_q [2];      // {sop, eop, data}
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;
  logic             full, push, push_eop, pop;
  logic [NUM_REQ-1:0] eligible;
  logic             win_found;
  logic [IDX_W-1:0] win_idx, cand;

  assign full     = (count_q == 2'd2);
  assign push     = (state_q == BUSY) && bus.reqValid_in[owner_q] && !full;
  assign push_eop = push && bus.reqEOP_in[owner_q];
  assign pop      = (count_q != 2'd0) && bus.txReady_in;

  // Only the owner sees ready, and only from registered state.
  always_comb begin
    bus.reqReady_out = '0;
    if (state_q == BUSY && !full) bus.reqReady_out[owner_q] = 1'b1;
  end

  // Candidates are SOP beats; in BUSY the owner's visible beat is the EOP being consumed, not a new packet.
  always_comb begin
    eligible = bus.reqValid_in & bus.reqSOP_in;
    if (state_q == BUSY) eligible[owner_q] = 1'b0;
  end

  // Round-robin scan starting just after the last grant, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state: grant from IDLE, or hand over / drop to IDLE on the owner's EOP accept.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = BUSY;
          owner_d = win_idx;
          last_d  = win_idx;
        end
      end
      BUSY: begin
        if (push_eop) begin
          if (win_found) begin
            owner_d = win_idx;
            last_d  = win_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM registers; requester 0 wins first after reset.
  always_ff @(posedge pcieClk_in or negedge pcieNReset_in) begin
    if (!pcieNReset_in) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Skid buffer storage and pointers; cleared on reset so all tx outputs read 0.
  always_ff @(posedge pcieClk_in or negedge pcieNReset_in) begin
    if (!pcieNReset_in) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        buf_q[wr_ptr_q] <= {bus.reqSOP_in[owner_q], bus.reqEOP_in[owner_q], bus.reqData_in[owner_q]};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.txValid_out = (count_q != 2'd0);
  assign {bus.txSOP_out, bus.txEOP_out, bus.txData_out} = buf_q[rd_ptr_q];
  assign bus.owner_out   = owner_q;
  assign bus.busy_out    = (state_q == BUSY) || (count_q != 2'd0);

`ifdef TX_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] pkt_count_q;

  // Count accepted EOP beats per requester; wraps naturally.
  always_ff @(posedge pcieClk_in or negedge pcieNReset_in) begin
    if (!pcieNReset_in) begin
      pkt_count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (push_eop && owner_q == IDX_W'(i)) pkt_count_q[i] <= pkt_count_q[i] + 32'd1;
      end
    end
  end

  assign bus.pktCount_out = pkt_count_q;
`endif
endmodule
